// File: rtl/div_radix2.sv
// div_radix2 -- multi-cycle radix-2 restoring divider (DIV / DIVU).
//
// Responder side of a start/annul/ready handshake. Operands are captured
// when a request is accepted in IDLE. After that, one quotient bit is
// produced per cycle. The block returns {remainder, quotient} for the
// HI/LO write-back.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = two's-complement divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request; the initiator holds it high until it sees ready_o
//   annul_i       abort (exception flush)
//   result_o      {remainder, quotient}; zero whenever ready_o is low
//   ready_o       result_o valid (registered)
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] quo;    // holds the dividend; shifts out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic             neg_q;
  logic             neg_r;
  logic             block;  // start still held from a finished request; wait for a low cycle

  logic [WIDTH-1:0] a_abs, b_abs;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  // Magnitudes are taken as unsigned WIDTH-bit values, so the most negative
  // number maps to itself and is still exact.
  assign a_abs = a_neg ? -opdata1_i : opdata1_i;
  assign b_abs = b_neg ? -opdata2_i : opdata2_i;

  // Trial subtract. The datapath is WIDTH+1 bits wide because the shifted
  // remainder can reach 2*dvs-1. The borrow out, diff[WIDTH], means
  // "does not fit".
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      block    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      block <= start_i & (block | (state == END));
      if (annul_i) begin
        state    <= IDLE;
        ready_o  <= 1'b0;
        result_o <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            ready_o  <= 1'b0;
            result_o <= '0;
            if (start_i && !block) begin
              cnt   <= '0;
              rem   <= '0;
              quo   <= a_abs;
              dvs   <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= (opdata2_i == '0) ? BYZERO : ON;
            end
          end
          BYZERO: begin
            // Divide by zero yields all-zero results. The sign fix of zero is still zero.
            rem   <= '0;
            quo   <= '0;
            state <= start_i ? END : IDLE;
          end
          ON: begin
            if (!start_i) begin
              state <= IDLE;
            end else begin
              rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
              cnt <= cnt + 1'b1;
              if (cnt == CW'(WIDTH - 1)) state <= END;
            end
          end
          END: begin
            if (!start_i) begin
              state    <= IDLE;
              ready_o  <= 1'b0;
              result_o <= '0;
            end else begin
              ready_o  <= 1'b1;
              result_o <= {r_fix, q_fix};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
module tb_div_radix2;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  div_radix2 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
    int             t0;
    string          name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_rdy = 1'b0;

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o && !prev_rdy) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ready: got result %h with no request outstanding", result_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result_o !== e.res || (cyc - e.t0) != e.lat) begin
          n_fail++;
          $display("FAIL %s: got %h after %0d cycles, expected %h after %0d",
                   e.name, result_o, cyc - e.t0, e.res, e.lat);
        end
      end
    end
    prev_rdy <= ready_o;
  end

  task automatic chk(input string name, input logic [2*W:0] got, input logic [2*W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name, input bit scramble);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_o) break;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom_range(3, 0);
        signed_div_i = $urandom_range(1, 0);
      end
    end
    if (!ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: ready_o=0 expected 1", name);
    end
  endtask

  // One full handshake: issue, wait, drop start, then check that ready falls next cycle.
  task automatic run(input string name, input logic sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2*W-1:0] exp, input int lat,
                     input bit scramble);
    exp_t e;
    @(negedge clk);
    e.res = exp; e.lat = lat; e.t0 = cyc + 1; e.name = name;
    sb_q.push_back(e);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    wait_ready(name, scramble);
    start_i = 1'b0;
    @(negedge clk);
    chk({name, "_drop"}, {ready_o, result_o}, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {ready_o, result_o}, '0);
    rst = 1'b0;

    run("divu_100_7",   0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 0);
    run("div_m7_2",     1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run("div_7_m2",     1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0);
    run("div_m100_m7",  1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33, 0);
    run("div_min_m1",   1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 0);
    run("divu_min_max", 0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33, 0);
    run("divu_max_1",   0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 0);
    run("divu_by0",     0, 32'd5,          32'd0,          64'h0,                 2,  0);
    run("div_by0",      1, 32'hFFFFFFF9,   32'd0,          64'h0,                 2,  0);

    // Annul at iteration 10: abort, nothing pushed so any ready is spurious.
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 32'd1234; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul_abort", {ready_o, result_o}, '0);
    repeat (40) @(negedge clk);
    chk("annul_quiet", {ready_o, result_o}, '0);
    run("divu_9_3",     0, 32'd9,          32'd3,          64'h00000000_00000003, 33, 0);

    // Annul in END with start still held: held start must not start a new divide.
    begin
      exp_t e;
      @(negedge clk);
      e.res = 64'h00000002_00000003; e.lat = 33; e.t0 = cyc + 1; e.name = "divu_20_6";
      sb_q.push_back(e);
      signed_div_i = 0; opdata1_i = 32'd20; opdata2_i = 32'd6; start_i = 1'b1;
      wait_ready("divu_20_6", 0);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul_end", {ready_o, result_o}, '0);
      repeat (40) @(negedge clk);
      chk("held_no_retrigger", {ready_o, result_o}, '0);
      start_i = 1'b0;
      @(negedge clk);
    end

    // Operands scrambled every cycle during the divide.
    run("divu_isolate", 0, 32'd1000,       32'd10,         64'h00000000_00000064, 33, 1);

    // Reset mid-divide.
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    chk("rst_mid", {ready_o, result_o}, '0);
    repeat (40) @(negedge clk);
    chk("rst_quiet", {ready_o, result_o}, '0);

    run("div_m9_4",     1, 32'hFFFFFFF7,   32'd4,          64'hFFFFFFFF_FFFFFFFE, 33, 0);

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d outstanding, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
